// File: rtl/key_event_arbiter.sv
// key_event_arbiter: per-key press detect, one-deep pending flags, round-robin event stream.
// Optional auto-repeat of held keys is built when KEY_HOLD_REPEAT_EN is defined.
module key_event_arbiter #(
  parameter int N_KEYS        = 4,
  parameter int REPEAT_CYCLES = 1000,
  localparam int IW = $clog2(N_KEYS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_press,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [IW-1:0]     evt_id,
  output logic [N_KEYS-1:0] pending,
  output logic              overflow
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t            state, state_n;
  logic [N_KEYS-1:0] prev, press, rpt, clr, drop, pending_n;
  logic [IW-1:0]     rr_ptr, rr_n, id_n, pick, sel;
  logic              valid_n, hs, found;

  if (N_KEYS < 2 || N_KEYS > 8 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("key_event_arbiter: parameter out of range");
  end

`ifdef KEY_HOLD_REPEAT_EN
  localparam int CW = $clog2(REPEAT_CYCLES);

  logic [CW-1:0] cnt [N_KEYS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_KEYS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (!key_press[i]) cnt[i] <= '0;
        else if (prev[i]) cnt[i] <= rpt[i] ? '0 : cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    rpt = '0;
    for (int i = 0; i < N_KEYS; i++)
      rpt[i] = key_press[i] & prev[i]
             & (cnt[i] == CW'(REPEAT_CYCLES - 1));
  end
`else
  assign rpt = '0;
`endif

  // A same-key handshake frees the slot, so a simultaneous press is queued
  always_comb begin
    hs          = evt_valid & evt_ready;
    clr         = '0;
    clr[evt_id] = hs;
    press       = (key_press & ~prev) | rpt;
    drop        = press & pending & ~clr;
    pending_n   = press | (pending & ~clr);
  end

  always_comb begin
    pick  = '0;
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= N_KEYS; k++) begin
      sel = IW'((int'(rr_ptr) + k) % N_KEYS);
      if (!found && pending[sel]) begin
        found = 1'b1;
        pick  = sel;
      end
    end
  end

  always_comb begin
    state_n = state;
    valid_n = evt_valid;
    id_n    = evt_id;
    rr_n    = rr_ptr;
    unique case (state)
      IDLE: begin
        if (|pending) begin
          state_n = OFFER;
          valid_n = 1'b1;
          id_n    = pick;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          state_n = IDLE;
          valid_n = 1'b0;
          rr_n    = evt_id;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      rr_ptr    <= IW'(N_KEYS - 1);
      pending   <= '0;
      prev      <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      evt_valid <= valid_n;
      evt_id    <= id_n;
      rr_ptr    <= rr_n;
      pending   <= pending_n;
      prev      <= key_press;
      overflow  <= |drop;
    end
  end

endmodule
